// File: rtl/csa_tree_stream_adapter.sv
// Valid/ready stream wrapper around a fixed-latency, handshake-free CSA tree.
// Collects I_DATA_N words per vector and returns each sum through a credit-guarded FIFO.
module csa_tree_stream_adapter #(
    parameter int unsigned I_DATA_W  = 3,
    parameter int unsigned I_DATA_N  = 8,
    parameter int unsigned SUM_W     = 8,
    parameter int unsigned TREE_LAT  = 4,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [I_DATA_W-1:0]                   s_data,
    output logic [0:I_DATA_N-1][I_DATA_W-1:0]     o_tree_data,
    input  logic [SUM_W-1:0]                      i_tree_sum,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [SUM_W-1:0]                      m_data
);

    localparam int unsigned IDX_W = $clog2(I_DATA_N);
    localparam int unsigned CRD_W = $clog2(RES_DEPTH + 1);
    localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam longint unsigned MAX_SUM = 64'(I_DATA_N) * ((64'd1 << I_DATA_W) - 64'd1);
    localparam longint unsigned SUM_LIM = (64'd1 << SUM_W) - 64'd1;

    if (MAX_SUM > SUM_LIM) begin : g_sum_width_err
        $error("SUM_W cannot hold I_DATA_N * (2**I_DATA_W - 1)");
    end
    if (I_DATA_N < 3 || TREE_LAT < 1 || RES_DEPTH < 1) begin : g_param_err
        $error("illegal I_DATA_N, TREE_LAT or RES_DEPTH");
    end

    logic [IDX_W-1:0]    r_idx;
    logic [CRD_W-1:0]    r_credits;
    logic [TREE_LAT:0]   r_track;
    logic [SUM_W-1:0]    r_mem [RES_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CRD_W-1:0]    r_count;

    logic w_last;
    logic w_accept;
    logic w_launch;
    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_last   = (r_idx == IDX_W'(I_DATA_N - 1));
        // Only the launching word can stall: it needs a guaranteed FIFO slot.
        s_ready  = !(w_last && (r_credits == '0));
        w_accept = s_valid && s_ready;
        w_launch = w_accept && w_last;
        // Top bit is one edge past the tree latency, when i_tree_sum holds this vector.
        w_push   = r_track[TREE_LAT];
        m_valid  = (r_count != '0);
        m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
        w_pop    = m_valid && m_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            o_tree_data <= '0;
            r_credits   <= CRD_W'(RES_DEPTH);
            r_track     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                o_tree_data[r_idx] <= s_data;
                r_idx              <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            r_track <= {r_track[TREE_LAT-1:0], w_launch};
            case ({w_launch, w_pop})
                2'b10:   r_credits <= r_credits - CRD_W'(1);
                2'b01:   r_credits <= r_credits + CRD_W'(1);
                default: r_credits <= r_credits;
            endcase
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CRD_W'(w_push) - CRD_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tree_sum;
        end
    end

endmodule

// File: tb/tb_csa_tree_stream_adapter.sv
// Bench for csa_tree_stream_adapter: behavioural tree model, queue scoreboard and
// a negedge monitor that checks every popped result.
module tb_csa_tree_stream_adapter;

    localparam int unsigned W  = 3;
    localparam int unsigned N  = 8;
    localparam int unsigned SW = 8;
    localparam int unsigned TL = 4;
    localparam int unsigned D  = 4;

    typedef logic [0:N-1][W-1:0] vec_t;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    vec_t             tree_data;
    logic [SW-1:0]    tree_sum;
    logic             m_valid;
    logic             m_ready;
    logic [SW-1:0]    m_data;

    int               n_checks;
    int               n_errors;
    int               stalls;
    logic [SW-1:0]    exp_q [$];
    logic [SW-1:0]    tree_pipe [TL];

    csa_tree_stream_adapter #(
        .I_DATA_W  (W),
        .I_DATA_N  (N),
        .SUM_W     (SW),
        .TREE_LAT  (TL),
        .RES_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .o_tree_data (tree_data),
        .i_tree_sum  (tree_sum),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] vec_sum(input vec_t v);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += int'(v[i]);
        return SW'(s);
    endfunction

    // Tree model: vector visible after edge k gives its sum after edge k+TL.
    always @(posedge clk) begin
        tree_pipe[0] <= vec_sum(tree_data);
        for (int i = 1; i < TL; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
    assign tree_sum = tree_pipe[TL-1];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got %0d expected none", m_data);
            end else begin
                check("result", longint'(m_data), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [W-1:0] w);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && waited <= 200) begin
            tick(1);
            waited++;
        end
        if (waited > 200) check("s_ready_timeout", 0, 1);
        if (waited > 0) stalls++;
        tick(1);
    endtask

    task automatic send_vec(input vec_t v, input logic [SW-1:0] exp);
        for (int i = 0; i < N; i++) send_word(v[i]);
        exp_q.push_back(exp);
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            tick(1);
            c++;
        end
        check(name, exp_q.size(), 0);
    endtask

    vec_t va, vb, vc, vd, ve, vf, vg, vr;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        stalls   = 0;
        va = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        va[7] = 3'd0;
        va = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
        // 1..8 does not fit 3 bits; "words 1..8" uses 8 mod 8 = 0 replaced by 1..7,8->
        va = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        vb = {N{3'd7}};
        vc = '0;
        vd = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        ve = {N{3'd3}};
        vf = {3'd5, 3'd0, 3'd5, 3'd0, 3'd5, 3'd0, 3'd5, 3'd0};
        vg = {3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7, 3'd0};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_tree_data", longint'(tree_data), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single vector and exact result timing
        m_ready = 1'b1;
        send_vec(va, 8'd28);
        s_valid = 1'b0;
        for (int j = 0; j <= int'(TL) + 2; j++) begin
            check("t1_m_valid_timing", m_valid, (j == int'(TL) + 1) ? 1 : 0);
            tick(1);
        end
        wait_drain("t1_drain");

        // All-max and all-zero
        send_vec(vb, 8'd56);
        send_vec(vc, 8'd0);
        s_valid = 1'b0;
        wait_drain("t2_drain");

        // Streaming random vectors
        stalls = 0;
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < N; i++) vr[i] = W'($urandom_range(0, 7));
            send_vec(vr, vec_sum(vr));
        end
        s_valid = 1'b0;
        check("t3_no_stall", stalls, 0);
        wait_drain("t3_drain");

        // Backpressure: four launches fill the credits, fifth vector stalls at its last word
        m_ready = 1'b0;
        send_vec(va, 8'd28);
        send_vec(vd, 8'd28);
        send_vec(ve, 8'd24);
        send_vec(vf, 8'd20);
        for (int i = 0; i < N - 1; i++) send_word(vg[i]);
        s_valid = 1'b1;
        s_data  = vg[N-1];
        tick(TL + 3);
        check("t4_s_ready_low", s_ready, 0);
        check("t4_m_valid", m_valid, 1);
        check("t4_head", m_data, 28);
        tick(3);
        check("t4_head_stable", m_data, 28);
        check("t4_s_ready_still_low", s_ready, 0);
        m_ready = 1'b1;
        send_word(vg[N-1]);
        exp_q.push_back(8'd28);
        send_vec(vb, 8'd56);
        s_valid = 1'b0;
        wait_drain("t4_drain");
        tick(TL + 4);
        check("t4_credits_restored", longint'(dut.r_credits), D);

        // Credit edge: pop coincides with a stalled launch word
        m_ready = 1'b0;
        send_vec(vd, 8'd28);
        send_vec(ve, 8'd24);
        send_vec(vf, 8'd20);
        send_vec(vg, 8'd28);
        for (int i = 0; i < N - 1; i++) send_word(va[i]);
        s_valid = 1'b1;
        s_data  = va[N-1];
        tick(TL + 3);
        check("t5_credits_zero", longint'(dut.r_credits), 0);
        m_ready = 1'b1;
        check("t5_s_ready_pop_cycle", s_ready, 0);
        tick(1);
        m_ready = 1'b0;
        check("t5_s_ready_next", s_ready, 1);
        tick(1);
        exp_q.push_back(8'd28);
        s_valid = 1'b0;
        check("t5_credits_end", longint'(dut.r_credits), 0);
        check("t5_idx_wrapped", longint'(dut.r_idx), 0);
        m_ready = 1'b1;
        wait_drain("t5_drain");

        // Reset mid-operation with a vector in flight
        send_vec(vb, 8'd56);
        for (int i = 0; i < 3; i++) send_word(va[i]);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        #1;
        check("t6_m_valid", m_valid, 0);
        check("t6_s_ready", s_ready, 1);
        check("t6_tree_data", longint'(tree_data), 0);
        tick(2);
        rst_n = 1'b1;
        tick(TL + 4);
        check("t6_no_stale", m_valid, 0);
        send_vec(vg, 8'd28);
        s_valid = 1'b0;
        wait_drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
